// File: rtl/ballot_if.sv
// ballot_if -- signal bundle between a round controller (master) and the
// ballot collector (slave).
//   open_i         : level request to start a new voting round
//   cast_i[3:0]    : per-voter cast strobe
//   choice_i[3:0]  : per-voter choice (1 = yes), qualified by cast_i
//   busy_o         : round in progress (OPEN or CLOSE)
//   voted_o[3:0]   : voters whose cast has been accepted this round
//   ballot_o[3:0]  : accepted yes-votes, feed to the popcount/threshold stage
//   ballot_valid_o : one-cycle pulse, ballot_o is final while high
interface ballot_if;
    logic       open_i;
    logic [3:0] cast_i;
    logic [3:0] choice_i;
    logic       busy_o;
    logic [3:0] voted_o;
    logic [3:0] ballot_o;
    logic       ballot_valid_o;

    modport master (
        output open_i, cast_i, choice_i,
        input  busy_o, voted_o, ballot_o, ballot_valid_o
    );

    modport slave (
        input  open_i, cast_i, choice_i,
        output busy_o, voted_o, ballot_o, ballot_valid_o
    );
endinterface

// File: rtl/ballot_collector.sv
// ballot_collector -- collects one vote per voter from four voters during a
// bounded voting round and presents the yes-vote mask for one cycle when the
// round closes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ballot_if.slave (open_i, cast_i, choice_i in;
//           busy_o, voted_o, ballot_o, ballot_valid_o out)
// Parameter TIMEOUT (2..65535): maximum number of cycles a round stays open.
// Optional build macro BALLOT_RECAST_EN: already-voted voters may recast
// (last cast wins) and a round closes only on timeout.
module ballot_collector #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic     clk,
    input  logic     rst_n,
    ballot_if.slave  bus
);

    localparam int unsigned     TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [3:0]    voted_r;
    logic [3:0]    voted_nxt_s;
    logic [3:0]    ballot_r;
    logic [3:0]    ballot_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          valid_r;
    logic          valid_nxt_s;
    logic [3:0]    accept_s;
    logic          all_voted_s;

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        voted_nxt_s  = voted_r;
        ballot_nxt_s = ballot_r;
        valid_nxt_s  = 1'b0;
        accept_s     = 4'b0000;
        all_voted_s  = 1'b0;

        case (state_r)
            IDLE: begin
                // Casts are ignored here; ballot_r keeps the last result.
                if (bus.open_i) begin
                    state_nxt_s  = OPEN;
                    timer_nxt_s  = {TW{1'b0}};
                    voted_nxt_s  = 4'b0000;
                    ballot_nxt_s = 4'b0000;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            OPEN: begin
`ifdef BALLOT_RECAST_EN
                accept_s    = bus.cast_i;
                all_voted_s = 1'b0;
`else
                accept_s    = bus.cast_i & ~voted_r;
                all_voted_s = ((voted_r | accept_s) == 4'b1111);
`endif
                voted_nxt_s  = voted_r | accept_s;
                ballot_nxt_s = (ballot_r & ~accept_s) | (bus.choice_i & accept_s);
                // Casts accepted on the closing edge still count, since
                // ballot/voted update on that same edge.
                if (all_voted_s || (timer_r == TIMER_LAST)) begin
                    state_nxt_s = CLOSE;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = OPEN;
                    // Cannot wrap: increment only below TIMER_LAST.
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            CLOSE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            timer_r  <= {TW{1'b0}};
            voted_r  <= 4'b0000;
            ballot_r <= 4'b0000;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            timer_r  <= timer_nxt_s;
            voted_r  <= voted_nxt_s;
            ballot_r <= ballot_nxt_s;
            busy_r   <= busy_nxt_s;
            valid_r  <= valid_nxt_s;
        end
    end

    assign bus.busy_o         = busy_r;
    assign bus.voted_o        = voted_r;
    assign bus.ballot_o       = ballot_r;
    assign bus.ballot_valid_o = valid_r;

endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector -- scoreboard bench for ballot_collector (TIMEOUT=8).
// Stimulus pushes the expected closing result (ballot, voted, closing edge
// number); a monitor on the falling edge pops and compares on every
// ballot_valid_o pulse.
module tb_ballot_collector;

    typedef struct {
        logic [3:0] ballot;
        logic [3:0] voted;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    ballot_if bus();

    ballot_collector #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to time-stamp closing edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] b, input logic [3:0] v, input int c);
        exp_t e;
        e.ballot = b;
        e.voted  = v;
        e.cyc    = c;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            step();
            n = n + 1;
        end
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_drain: %0d pending results, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.ballot_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_valid: pulse at edge %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_ballot", {28'd0, bus.ballot_o}, {28'd0, e.ballot});
                chk("valid_voted",  {28'd0, bus.voted_o},  {28'd0, e.voted});
                chk("valid_busy",   {31'd0, bus.busy_o},   32'd1);
                chk("valid_edge",   cyc, e.cyc);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b1;
        bus.open_i = 1'b0;
        bus.cast_i = 4'b0000;
        bus.choice_i = 4'b0000;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy",   {31'd0, bus.busy_o},         32'd0);
        chk("rst_voted",  {28'd0, bus.voted_o},        32'd0);
        chk("rst_ballot", {28'd0, bus.ballot_o},       32'd0);
        chk("rst_valid",  {31'd0, bus.ballot_valid_o}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // All four vote in one cycle: early close on the next edge.
        bus.open_i = 1'b1;
        step();
        k = cyc;
        bus.open_i = 1'b0;
        chk("a_busy_open", {31'd0, bus.busy_o}, 32'd1);
        bus.cast_i = 4'b1111;
        bus.choice_i = 4'b1010;
        push(4'b1010, 4'b1111, k + 1);
        step();
        bus.cast_i = 4'b0000;
        chk("a_busy_close", {31'd0, bus.busy_o}, 32'd1);
        step();
        chk("a_busy_idle", {31'd0, bus.busy_o}, 32'd0);
        // IDLE ignores casts and holds the last result.
        bus.cast_i = 4'b1111;
        bus.choice_i = 4'b0101;
        step();
        step();
        bus.cast_i = 4'b0000;
        chk("a_idle_hold_ballot", {28'd0, bus.ballot_o}, 32'ha);
        chk("a_idle_hold_voted",  {28'd0, bus.voted_o},  32'hf);
        chk("a_idle_busy",        {31'd0, bus.busy_o},   32'd0);
        wait_drain("a");

        // Single yes-vote: round closes on timeout, 8 edges after open.
        bus.open_i = 1'b1;
        step();
        k = cyc;
        bus.open_i = 1'b0;
        chk("b_open_clr_ballot", {28'd0, bus.ballot_o}, 32'd0);
        chk("b_open_clr_voted",  {28'd0, bus.voted_o},  32'd0);
        bus.cast_i = 4'b0001;
        bus.choice_i = 4'b0001;
        push(4'b0001, 4'b0001, k + 8);
        step();
        bus.cast_i = 4'b0000;
        wait_drain("b");
        step();
        chk("b_busy_after", {31'd0, bus.busy_o}, 32'd0);

        // Voter 2 votes yes, then tries to change to no two cycles later.
        bus.open_i = 1'b1;
        step();
        k = cyc;
        bus.open_i = 1'b0;
`ifdef BALLOT_RECAST_EN
        push(4'b0000, 4'b0100, k + 8);
`else
        push(4'b0100, 4'b0100, k + 8);
`endif
        bus.cast_i = 4'b0100;
        bus.choice_i = 4'b0100;
        step();
        bus.cast_i = 4'b0000;
        step();
        bus.cast_i = 4'b0100;
        bus.choice_i = 4'b0000;
        step();
        bus.cast_i = 4'b0000;
        wait_drain("c");
        step();

        // Late cast on the final edge counts; open_i held high throughout.
        bus.open_i = 1'b1;
        step();
        k = cyc;
        bus.cast_i = 4'b0011;
        bus.choice_i = 4'b0001;
        push(4'b1001, 4'b1011, k + 8);
        step();
        bus.cast_i = 4'b0000;
        step();
        step();
        chk("d_no_restart_voted", {28'd0, bus.voted_o}, 32'h3);
        repeat (4) step();
        bus.cast_i = 4'b1000;
        bus.choice_i = 4'b1000;
        step();
        bus.cast_i = 4'b0000;
        chk("d_busy_close", {31'd0, bus.busy_o}, 32'd1);
        step();
        chk("d_idle_busy",   {31'd0, bus.busy_o},   32'd0);
        chk("d_idle_ballot", {28'd0, bus.ballot_o}, 32'h9);
        bus.open_i = 1'b0;
        wait_drain("d");
        step();

        // Reset mid-round discards it without a valid pulse.
        bus.open_i = 1'b1;
        step();
        bus.open_i = 1'b0;
        bus.cast_i = 4'b0011;
        bus.choice_i = 4'b0011;
        step();
        bus.cast_i = 4'b0000;
        step();
        chk("e_voted_mid", {28'd0, bus.voted_o}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_busy",   {31'd0, bus.busy_o},         32'd0);
        chk("e_rst_voted",  {28'd0, bus.voted_o},        32'd0);
        chk("e_rst_ballot", {28'd0, bus.ballot_o},       32'd0);
        chk("e_rst_valid",  {31'd0, bus.ballot_valid_o}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("e_after_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("e_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ballot_collector.md
BALLOT_COLLECTOR -- requirements
Module: ballot_collector

Interface
REQ-001 Parameter TIMEOUT, default 1000, meaning the maximum number of clock cycles a voting round stays open; legal range 2..65535.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 Port open_i, input, 1 bit: level, synchronous; requests a new round.
REQ-005 Port cast_i, input, 4 bits: per-voter cast strobe; bit i high means voter i casts this cycle.
REQ-006 Port choice_i, input, 4 bits: per-voter choice, sampled with cast_i; 1 = yes, 0 = no.
REQ-007 Port busy_o, output, 1 bit: high while a round is open.
REQ-008 Port voted_o, output, 4 bits: bit i set once voter i's cast is accepted.
REQ-009 Port ballot_o, output, 4 bits: accepted yes-votes; this is the feed to the downstream popcount/threshold comparator.
REQ-010 Port ballot_valid_o, output, 1 bit: one-cycle pulse; ballot_o is final while it is high.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, OPEN, CLOSE.
REQ-012 IDLE: open_i high at an edge -> go to OPEN; clear ballot_o, voted_o and the timer to 0 on that same edge.
REQ-013 In IDLE, ballot_o SHALL hold the last closed round's result.
REQ-014 OPEN: at each edge, for every bit i with cast_i[i]=1 and voted_o[i]=0, set voted_o[i]=1 and ballot_o[i]=choice_i[i].
REQ-015 Simultaneous casts by several voters in one cycle SHALL all be accepted.
REQ-016 A cast by a voter whose voted_o bit is already set SHALL be ignored (unless the REQ-027 feature is compiled in).
REQ-017 OPEN -> CLOSE SHALL occur on the edge where the updated voted_o equals 4'b1111, or where the timer equals TIMEOUT-1, whichever comes first.
REQ-018 A cast accepted on that same closing edge SHALL be counted.
REQ-019 The timer SHALL increment by 1 each OPEN cycle, be ceil(log2(TIMEOUT)) bits wide, and never wrap.
REQ-020 CLOSE SHALL last exactly one cycle with ballot_valid_o=1, then go unconditionally to IDLE.
REQ-021 Latency: ballot_valid_o is high in the cycle immediately after the closing edge.
REQ-022 busy_o SHALL be high exactly in OPEN and CLOSE.
REQ-023 open_i SHALL be ignored in OPEN and CLOSE; a new round requires open_i sampled in IDLE.
REQ-024 In IDLE, cast_i and choice_i SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force state IDLE, timer 0, busy_o 0, voted_o 4'b0000, ballot_o 4'b0000 and ballot_valid_o 0.
REQ-026 Reset asserted mid-round SHALL discard the round with no ballot_valid_o pulse; release is synchronous to the next clk edge.

Configuration
REQ-027 Macro BALLOT_RECAST_EN, when defined: an OPEN-state cast by an already-voted voter overwrites ballot_o[i] with choice_i[i], so the last cast wins.
REQ-028 With BALLOT_RECAST_EN defined, the all-voted early close of REQ-017 is disabled, so a round closes only on timeout.
REQ-029 With BALLOT_RECAST_EN undefined, the behaviour is exactly REQ-014..REQ-017.

Verification (bench TIMEOUT=8)
REQ-030 Reset mid-OPEN with voted_o=4'b0011 -> all outputs 0 before the next clk edge; no ballot_valid_o pulse.
REQ-031 open_i pulse, then in one cycle cast_i=4'b1111, choice_i=4'b1010 -> next cycle ballot_valid_o=1, ballot_o=4'b1010, voted_o=4'b1111; following cycle busy_o=0.
REQ-032 open_i, then cast voter 0 yes only -> ballot_valid_o pulses 8 cycles after the open edge; ballot_o=4'b0001, voted_o=4'b0001.
REQ-033 Voter 2 casts yes, then casts no 2 cycles later -> ballot_o[2]=1 (recast ignored); with BALLOT_RECAST_EN defined -> ballot_o[2]=0 and close occurs only on timeout.
REQ-034 Voter 3 casts on the timer=7 edge -> accepted; ballot_o[3] reflects its choice in the valid cycle; open_i held high during OPEN/CLOSE -> no restart until IDLE.
